issue_scoreboard: RTL and testbench

- Issue-control block between the decode stage and the execute pipes of the RV64 core.
- Keeps a per-register pending-write scoreboard for the general register file.
- Stalls decode on RAW and WAW hazards, and serialises CSR instructions: it drains all outstanding writes, issues the CSR instruction alone, then waits for its completion.
- Owns the decode-stage ready signal and a stall performance counter.

---
 rtl/issue_scoreboard_pkg.sv | 23 ++
 rtl/issue_scoreboard_chk.sv | 17 +
 rtl/issue_scoreboard_regs.sv | 59 +++++
 rtl/issue_scoreboard.sv | 143 ++++++++++++++
 tb/tb_issue_scoreboard.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/issue_scoreboard_pkg.sv
// Shared constants for the issue scoreboard: register-file geometry,
// FSM state encodings and a one-hot index decoder.
package issue_scoreboard_pkg;

  localparam int SB_NUM_GRF = 32;
  localparam int GRF_IDX_W  = 5;

  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_DRAIN    = 2'd1;
  localparam logic [1:0] ST_CSR_WAIT = 2'd2;

  function automatic logic [SB_NUM_GRF-1:0] idx_onehot(input logic [GRF_IDX_W-1:0] idx,
                                                       input logic en);
    logic [SB_NUM_GRF-1:0] one;
    one = {{(SB_NUM_GRF-1){1'b0}}, 1'b1};
    if (en) begin
      idx_onehot = one << idx;
    end else begin
      idx_onehot = {SB_NUM_GRF{1'b0}};
    end
  endfunction

endpackage

// File: rtl/issue_scoreboard_chk.sv
// Protocol checker: a CSR instruction waiting in DRAIN must stay presented
// by decode until it either issues or is flushed.
module issue_scoreboard_chk
  import issue_scoreboard_pkg::*;
(
  input logic       clk_i,
  input logic       rst_ni,
  input logic [1:0] state_i,
  input logic       dec_valid_i,
  input logic       flush_i
);

  a_drain_hold: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_i == ST_DRAIN) |-> (dec_valid_i | flush_i))
    else $error("decode dropped the CSR instruction while draining");

endmodule

// File: rtl/issue_scoreboard_regs.sv
// Pending-write vector for the integer register file with set-over-clear
// priority, x0 masking and the per-index hazard (eff) lookups.
module issue_scoreboard_regs
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_GRF   = SB_NUM_GRF,
  parameter int BYPASS_WB = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wb0_valid_i,
  input  logic [GRF_IDX_W-1:0] wb0_rd_i,
  input  logic                 wb1_valid_i,
  input  logic [GRF_IDX_W-1:0] wb1_rd_i,
  input  logic                 set_en_i,
  input  logic [GRF_IDX_W-1:0] set_rd_i,
  input  logic [GRF_IDX_W-1:0] rs1_i,
  input  logic [GRF_IDX_W-1:0] rs2_i,
  input  logic [GRF_IDX_W-1:0] rd_i,
  output logic [NUM_GRF-1:0]   pend_o,
  output logic                 eff_rs1_o,
  output logic                 eff_rs2_o,
  output logic                 eff_rd_o,
  output logic                 drain_empty_o
);

  localparam logic BYP = (BYPASS_WB != 0);

  logic [NUM_GRF-1:0] pend_q;
  logic [NUM_GRF-1:0] pend_d;
  logic [NUM_GRF-1:0] clr_s;
  logic [NUM_GRF-1:0] set_s;
  logic [NUM_GRF-1:0] eff_s;
  logic [NUM_GRF-1:0] x0_mask_s;

  assign x0_mask_s = {{(NUM_GRF-1){1'b1}}, 1'b0};
  assign clr_s     = idx_onehot(wb0_rd_i, wb0_valid_i) | idx_onehot(wb1_rd_i, wb1_valid_i);
  assign set_s     = idx_onehot(set_rd_i, set_en_i);

  // A register retiring this cycle is already forwardable when bypass exists.
  assign eff_s     = pend_q & ~(BYP ? clr_s : {NUM_GRF{1'b0}});
  assign pend_d    = ((pend_q & ~clr_s) | set_s) & x0_mask_s;

  assign eff_rs1_o     = eff_s[rs1_i];
  assign eff_rs2_o     = eff_s[rs2_i];
  assign eff_rd_o      = eff_s[rd_i];
  assign drain_empty_o = ((pend_q & ~clr_s) == {NUM_GRF{1'b0}});
  assign pend_o        = pend_q;

  // Pending vector register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_q <= {NUM_GRF{1'b0}};
    end else begin
      pend_q <= pend_d;
    end
  end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue control between decode and execute: RAW/WAW stalls via the pending
// scoreboard, CSR serialisation FSM, decode ready and a stall counter.
module issue_scoreboard
  import issue_scoreboard_pkg::*;
#(
  parameter int NUM_GRF   = SB_NUM_GRF,
  parameter int BYPASS_WB = 1,
  parameter int CNT_W     = 32
) (
  input  logic             i_Clk,
  input  logic             i_Rst_n,
  input  logic             i_DecValid,
  output logic             o_DecReady,
  input  logic [4:0]       i_Rs1_5,
  input  logic             i_Rs1Use,
  input  logic [4:0]       i_Rs2_5,
  input  logic             i_Rs2Use,
  input  logic [4:0]       i_Rd_5,
  input  logic             i_RdWen,
  input  logic             i_IsCsr,
  input  logic             i_Flush,
  input  logic             i_Wb0Valid,
  input  logic [4:0]       i_Wb0Rd_5,
  input  logic             i_Wb1Valid,
  input  logic [4:0]       i_Wb1Rd_5,
  input  logic             i_CsrDone,
  output logic             o_Issue,
  output logic [31:0]      o_Pending_32,
  output logic [1:0]       o_State_2,
  output logic [CNT_W-1:0] o_StallCnt
);

  logic [1:0]         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_GRF-1:0] pend_s;
  logic               eff_rs1_s, eff_rs2_s, eff_rd_s, drain_empty_s;
  logic               raw_s, waw_s, ready_s, dec_ready_s, fire_s, stall_s;

  issue_scoreboard_regs #(
    .NUM_GRF   (NUM_GRF),
    .BYPASS_WB (BYPASS_WB)
  ) u_regs (
    .clk_i         (i_Clk),
    .rst_ni        (i_Rst_n),
    .wb0_valid_i   (i_Wb0Valid),
    .wb0_rd_i      (i_Wb0Rd_5),
    .wb1_valid_i   (i_Wb1Valid),
    .wb1_rd_i      (i_Wb1Rd_5),
    .set_en_i      (fire_s & i_RdWen),
    .set_rd_i      (i_Rd_5),
    .rs1_i         (i_Rs1_5),
    .rs2_i         (i_Rs2_5),
    .rd_i          (i_Rd_5),
    .pend_o        (pend_s),
    .eff_rs1_o     (eff_rs1_s),
    .eff_rs2_o     (eff_rs2_s),
    .eff_rd_o      (eff_rd_s),
    .drain_empty_o (drain_empty_s)
  );

  issue_scoreboard_chk u_chk (
    .clk_i       (i_Clk),
    .rst_ni      (i_Rst_n),
    .state_i     (state_q),
    .dec_valid_i (i_DecValid),
    .flush_i     (i_Flush)
  );

  assign raw_s = (i_Rs1Use & eff_rs1_s) | (i_Rs2Use & eff_rs2_s);
  assign waw_s = i_RdWen & eff_rd_s;

  // Decode-ready per FSM state.
  always_comb begin
    ready_s = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (i_IsCsr) begin
          ready_s = 1'b0;
        end else begin
          ready_s = ~raw_s & ~waw_s & ~i_Flush;
        end
      end
      ST_DRAIN:    ready_s = drain_empty_s & ~i_Flush;
      ST_CSR_WAIT: ready_s = 1'b0;
      default:     ready_s = 1'b0;
    endcase
  end

  assign dec_ready_s = ready_s & i_Rst_n;
  assign fire_s      = i_DecValid & dec_ready_s;
  assign stall_s     = i_DecValid & ~dec_ready_s & ~i_Flush;

  // CSR serialisation: drain outstanding writes, issue alone, await completion.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN: begin
        if (i_DecValid & i_IsCsr & ~i_Flush) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (i_Flush) begin
          state_d = ST_RUN;
        end else if (fire_s) begin
          state_d = ST_CSR_WAIT;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_CSR_WAIT: begin
        if (i_CsrDone) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_CSR_WAIT;
        end
      end
      default: state_d = ST_RUN;
    endcase
  end

  assign cnt_d = (stall_s & ~(&cnt_q)) ? (cnt_q + {{(CNT_W-1){1'b0}}, 1'b1}) : cnt_q;

  // State and saturating stall counter.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q <= ST_RUN;
      cnt_q   <= {CNT_W{1'b0}};
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_DecReady   = dec_ready_s;
  assign o_Issue      = fire_s;
  assign o_Pending_32 = pend_s;
  assign o_State_2    = state_q;
  assign o_StallCnt   = cnt_q;

endmodule

// File: tb/tb_issue_scoreboard.sv
// Self-checking bench for issue_scoreboard: directed scenarios followed by
// random traffic, all compared against a register-array reference model.
module tb_issue_scoreboard;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_DecValid, o_DecReady;
  logic [4:0]  i_Rs1_5, i_Rs2_5, i_Rd_5, i_Wb0Rd_5, i_Wb1Rd_5;
  logic        i_Rs1Use, i_Rs2Use, i_RdWen, i_IsCsr, i_Flush;
  logic        i_Wb0Valid, i_Wb1Valid, i_CsrDone, o_Issue;
  logic [31:0] o_Pending_32;
  logic [1:0]  o_State_2;
  logic [31:0] o_StallCnt;

  int n_chk  = 0;
  int n_fail = 0;

  // reference model: one flag per register, state as 0=RUN 1=DRAIN 2=CSR_WAIT
  bit          pend_m[32];
  int          st_m;
  logic [31:0] cnt_m;

  issue_scoreboard #(.NUM_GRF(32), .BYPASS_WB(1), .CNT_W(32)) dut (
    .i_Clk(i_Clk), .i_Rst_n(i_Rst_n), .i_DecValid(i_DecValid), .o_DecReady(o_DecReady),
    .i_Rs1_5(i_Rs1_5), .i_Rs1Use(i_Rs1Use), .i_Rs2_5(i_Rs2_5), .i_Rs2Use(i_Rs2Use),
    .i_Rd_5(i_Rd_5), .i_RdWen(i_RdWen), .i_IsCsr(i_IsCsr), .i_Flush(i_Flush),
    .i_Wb0Valid(i_Wb0Valid), .i_Wb0Rd_5(i_Wb0Rd_5), .i_Wb1Valid(i_Wb1Valid),
    .i_Wb1Rd_5(i_Wb1Rd_5), .i_CsrDone(i_CsrDone), .o_Issue(o_Issue),
    .o_Pending_32(o_Pending_32), .o_State_2(o_State_2), .o_StallCnt(o_StallCnt)
  );

  always #5 i_Clk = ~i_Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic bit retiring(input int r);
    return (i_Wb0Valid && int'(i_Wb0Rd_5) == r) || (i_Wb1Valid && int'(i_Wb1Rd_5) == r);
  endfunction

  function automatic bit busy(input int r);
    return (r != 0) && pend_m[r] && !retiring(r);
  endfunction

  function automatic bit m_ready();
    if (!i_Rst_n) return 1'b0;
    if (st_m == 0) begin
      if (i_IsCsr) return 1'b0;
      return !(i_Rs1Use && busy(int'(i_Rs1_5))) && !(i_Rs2Use && busy(int'(i_Rs2_5)))
             && !(i_RdWen && busy(int'(i_Rd_5))) && !i_Flush;
    end
    if (st_m == 1) begin
      for (int r = 0; r < 32; r++) if (pend_m[r] && !retiring(r)) return 1'b0;
      return !i_Flush;
    end
    return 1'b0;
  endfunction

  function automatic logic [31:0] m_vec();
    logic [31:0] v = 32'd0;
    for (int r = 0; r < 32; r++) v[r] = pend_m[r];
    return v;
  endfunction

  task automatic m_reset();
    for (int r = 0; r < 32; r++) pend_m[r] = 1'b0;
    st_m  = 0;
    cnt_m = 32'd0;
  endtask

  // one clock: check outputs against the model, then advance the model
  task automatic step();
    bit rdy, fire;
    bit nxt[32];
    int nst;
    #1;
    rdy  = m_ready();
    fire = i_DecValid && rdy;
    chk("ready", {31'd0, o_DecReady}, {31'd0, rdy});
    chk("issue", {31'd0, o_Issue}, {31'd0, fire});
    chk("pending", o_Pending_32, m_vec());
    chk("state", {30'd0, o_State_2}, st_m);
    chk("stallcnt", o_StallCnt, cnt_m);
    for (int r = 0; r < 32; r++) nxt[r] = pend_m[r] && !retiring(r);
    if (fire && i_RdWen && i_Rd_5 != 5'd0) nxt[i_Rd_5] = 1'b1;
    nst = st_m;
    case (st_m)
      0: if (i_DecValid && i_IsCsr && !i_Flush) nst = 1;
      1: if (i_Flush) nst = 0; else if (fire) nst = 2;
      default: if (i_CsrDone) nst = 0;
    endcase
    @(posedge i_Clk);
    for (int r = 0; r < 32; r++) pend_m[r] = nxt[r];
    if (i_DecValid && !rdy && !i_Flush && cnt_m != 32'hFFFF_FFFF) cnt_m = cnt_m + 32'd1;
    st_m = nst;
    @(negedge i_Clk);
  endtask

  task automatic inst(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                      input int rd, input bit w, input bit csr);
    i_DecValid = v;   i_Rs1_5 = 5'(rs1); i_Rs1Use = u1; i_Rs2_5 = 5'(rs2); i_Rs2Use = u2;
    i_Rd_5 = 5'(rd);  i_RdWen = w;       i_IsCsr = csr;
  endtask

  task automatic wb(input bit v0, input int r0, input bit v1, input int r1);
    i_Wb0Valid = v0; i_Wb0Rd_5 = 5'(r0); i_Wb1Valid = v1; i_Wb1Rd_5 = 5'(r1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ready"}, {31'd0, o_DecReady}, 32'd0);
    chk({tag, "_issue"}, {31'd0, o_Issue}, 32'd0);
    chk({tag, "_pend"}, o_Pending_32, 32'd0);
    chk({tag, "_state"}, {30'd0, o_State_2}, 32'd0);
    chk({tag, "_cnt"}, o_StallCnt, 32'd0);
  endtask

  initial begin
    i_Rst_n = 1'b0; i_Flush = 1'b0; i_CsrDone = 1'b0;
    inst(1, 0, 0, 0, 0, 0, 0, 0);
    wb(0, 0, 0, 0);
    m_reset();
    #2 chk_all_zero("reset");
    @(negedge i_Clk);
    i_Rst_n = 1'b1;
    inst(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // RAW on x5, released by writeback bypass in the same cycle
    inst(1, 0, 0, 0, 0, 5, 1, 0); step();
    inst(1, 5, 1, 0, 0, 6, 1, 0); step(); step(); step();
    chk("raw_stallcnt", o_StallCnt, 32'd3);
    wb(1, 5, 0, 0); step();
    wb(0, 0, 0, 0); inst(0, 0, 0, 0, 0, 0, 0, 0);
    wb(1, 6, 0, 0); step(); wb(0, 0, 0, 0);

    // WAW on x7: set wins over the same-cycle clear
    inst(1, 0, 0, 0, 0, 7, 1, 0); step();
    step(); step();
    wb(0, 0, 1, 7); step();
    chk("waw_bit7", {31'd0, o_Pending_32[7]}, 32'd1);
    inst(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 7, 0, 0); step(); wb(0, 0, 0, 0);

    // CSR drain with x3 and x9 outstanding
    inst(1, 0, 0, 0, 0, 3, 1, 0); step();
    inst(1, 0, 0, 0, 0, 9, 1, 0); step();
    inst(1, 1, 1, 0, 0, 4, 1, 1); step();
    chk("csr_in_drain", {30'd0, o_State_2}, 32'd1);
    step();
    wb(1, 3, 0, 0); step();
    wb(0, 0, 1, 9); step();
    chk("csr_in_wait", {30'd0, o_State_2}, 32'd2);
    wb(0, 0, 0, 0); inst(1, 2, 1, 0, 0, 10, 1, 0); step(); step();
    i_CsrDone = 1'b1; wb(1, 4, 0, 0); step();
    i_CsrDone = 1'b0; wb(0, 0, 0, 0); step();
    chk("after_csr_pend", o_Pending_32, 32'h0000_0400);
    inst(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 10, 0, 0); step(); wb(0, 0, 0, 0);

    // x0 never becomes pending and never hazards
    inst(1, 0, 0, 0, 0, 0, 1, 0); step();
    inst(1, 0, 1, 0, 1, 0, 1, 0); step();
    chk("x0_pend", o_Pending_32, 32'd0);

    // flush in DRAIN, then flush of a hazard-free instruction in RUN
    inst(1, 0, 0, 0, 0, 6, 1, 0); step();
    inst(1, 0, 0, 0, 0, 0, 0, 1); step();
    i_Flush = 1'b1; step();
    chk("flush_drain_state", {30'd0, o_State_2}, 32'd0);
    i_Flush = 1'b0; inst(0, 0, 0, 0, 0, 0, 0, 0); wb(0, 0, 1, 6); step(); wb(0, 0, 0, 0);
    inst(1, 0, 0, 0, 0, 12, 1, 0); i_Flush = 1'b1; step();
    i_Flush = 1'b0; inst(0, 0, 0, 0, 0, 0, 0, 0); step();
    chk("flush_run_pend", o_Pending_32, 32'd0);

    // reach CSR_WAIT with x11 pending and a nonzero stall count, then reset
    inst(1, 0, 0, 0, 0, 8, 1, 0); step();
    inst(1, 0, 0, 0, 0, 11, 1, 1); step();
    wb(1, 8, 0, 0); step(); wb(0, 0, 0, 0);
    inst(1, 11, 1, 0, 0, 8, 1, 0); step(); step(); step();
    i_Rst_n = 1'b0; #1 chk_all_zero("midreset");
    m_reset();
    #1 i_Rst_n = 1'b1;
    inst(0, 0, 0, 0, 0, 0, 0, 0); wb(1, 8, 0, 0); step();
    chk("post_reset_wb", o_Pending_32, 32'd0);
    wb(0, 0, 0, 0);

    // random traffic on a small register window to provoke hazards
    for (int n = 0; n < 600; n++) begin
      if (st_m == 1) begin
        i_DecValid = 1'b1;
        i_Flush    = ($urandom_range(0, 7) == 0);
      end else begin
        inst($urandom_range(0, 3) != 0, $urandom_range(0, 7), 1'($urandom_range(0, 1)),
             $urandom_range(0, 7), 1'($urandom_range(0, 1)), $urandom_range(0, 7),
             1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0);
        i_Flush = ($urandom_range(0, 9) == 0);
      end
      wb($urandom_range(0, 2) == 0, $urandom_range(0, 7),
         $urandom_range(0, 3) == 0, $urandom_range(0, 7));
      i_CsrDone = ($urandom_range(0, 3) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
